// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder back end.
// Single-precision layout, FSM state encoding, special results.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp32_t;

  localparam fp32_t FP_ZERO = '0;
  localparam fp32_t FP_INF  = '{
    sign:     1'b0,
    exponent: '1,
    mantissa: '0
  };

endpackage

// File: rtl/round_nearest_even.sv
// Round-to-nearest-even increment on a hidden+fraction mantissa.
// Carry flags a rollover to the next binade.
module round_nearest_even #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0] man_i,
  input  logic           g_i,
  input  logic           r_i,
  input  logic           s_i,
  output logic [MAN_W:0] man_o,
  output logic           carry_o
);

  logic up;

  assign up = g_i & (r_i | s_i | man_i[0]);

  assign {carry_o, man_o} = {1'b0, man_i} + (MAN_W+2)'(up);

endmodule

// File: rtl/normalize_round.sv
// FP adder back end: iterative normalise then RNE round.
// One operation in flight, valid/ready on both sides.
module normalize_round #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic             sign,
  input  logic [EXP_W-1:0] exponentIn,
  input  logic [MAN_W+1:0] sumMantissa,
  input  logic             guardBit,
  input  logic             roundBit,
  input  logic             stickyBit,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      result,
  output logic             overflow,
  output logic             underflow
);

  import fp_pkg::*;

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_LIM =
    (EXP_W+1)'((1 << EXP_W) - 1);

  norm_state_t      state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [MAN_W+1:0] man_q, man_d;
  logic             g_q, g_d;
  logic             r_q, r_d;
  logic             s_q, s_d;
  fp32_t            res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [MAN_W:0]   rnd_man;
  logic             rnd_carry;
  logic [EXP_W:0]   exp_r;
  logic [MAN_W-1:0] frac_r;

  round_nearest_even #(
    .MAN_W(MAN_W)
  ) u_rne (
    .man_i  (man_q[MAN_W:0]),
    .g_i    (g_q),
    .r_i    (r_q),
    .s_i    (s_q),
    .man_o  (rnd_man),
    .carry_o(rnd_carry)
  );

  // A rounding carry leaves 1.000.., so the shifted fraction is the upper bits
  assign exp_r  = exp_q + {{EXP_W{1'b0}}, rnd_carry};
  assign frac_r = rnd_carry ? rnd_man[MAN_W:1]
                            : rnd_man[MAN_W-1:0];

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    man_d   = man_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          sign_d  = sign;
          exp_d   = {1'b0, exponentIn};
          man_d   = sumMantissa;
          g_d     = guardBit;
          r_d     = roundBit;
          s_d     = stickyBit;
          state_d = NORM;
        end
      end
      NORM: begin
        if (man_q == '0 && !(g_q | r_q | s_q)) begin
          res_d   = FP_ZERO;
          state_d = DONE;
        end else if (man_q[MAN_W+1]) begin
          s_d     = s_q | r_q;
          r_d     = g_q;
          g_d     = man_q[0];
          man_d   = man_q >> 1;
          exp_d   = exp_q + EXP_ONE;
          state_d = ROUND;
        end else if (man_q[MAN_W]) begin
          state_d = ROUND;
        end else if (exp_q <= EXP_ONE) begin
          unf_d      = 1'b1;
          res_d      = FP_ZERO;
          res_d.sign = sign_q;
          state_d    = DONE;
        end else begin
          man_d = {man_q[MAN_W:0], g_q};
          g_d   = r_q;
          r_d   = 1'b0;
          exp_d = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        if (exp_r >= EXP_LIM) begin
          ovf_d      = 1'b1;
          res_d      = FP_INF;
          res_d.sign = sign_q;
        end else begin
          res_d.sign     = sign_q;
          res_d.exponent = exp_r[EXP_W-1:0];
          res_d.mantissa = frac_r;
        end
        state_d = DONE;
      end
      DONE: begin
        if (outReady) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      res_q   <= FP_ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign inReady   = (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: values, latency,
// backpressure and asynchronous abort.
module tb_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic        sign;
  logic [7:0]  exponentIn;
  logic [24:0] sumMantissa;
  logic        guardBit;
  logic        roundBit;
  logic        stickyBit;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  normalize_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .sign       (sign),
    .exponentIn (exponentIn),
    .sumMantissa(sumMantissa),
    .guardBit   (guardBit),
    .roundBit   (roundBit),
    .stickyBit  (stickyBit),
    .outValid   (outValid),
    .outReady   (outReady),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic send(input logic s, input logic [7:0] e,
                      input logic [24:0] m, input logic g,
                      input logic r, input logic st);
    @(negedge clk);
    sign        = s;
    exponentIn  = e;
    sumMantissa = m;
    guardBit    = g;
    roundBit    = r;
    stickyBit   = st;
    inValid     = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // Cycle count equals the budget when outValid never rises
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (outValid === 1'b1) break;
    end
  endtask

  task automatic ack();
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("FAIL reset_inReady got %b want 1", inReady);
    end
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL reset_outValid got %b want 0", outValid);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want 0", result);
    end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b%b want 00", overflow, underflow);
    end
  endtask

  task automatic test_normalised();
    int cyc;
    send(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 3) begin
      errors++; $display("FAIL norm_latency got %0d want 3", cyc);
    end
    checks++;
    if (result !== 32'h40000000) begin
      errors++; $display("FAIL norm_result got %h want 40000000", result);
    end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL norm_flags got %b%b want 00", overflow, underflow);
    end
    ack();
  endtask

  task automatic test_cancellation();
    int cyc;
    send(1'b0, 8'd130, 25'h0000001, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 26) begin
      errors++; $display("FAIL cancel_latency got %0d want 26", cyc);
    end
    checks++;
    if (result !== 32'h35800000) begin
      errors++; $display("FAIL cancel_result got %h want 35800000", result);
    end
    ack();
  endtask

  task automatic test_rne();
    int cyc;
    send(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (result !== 32'h3F800002) begin
      errors++; $display("FAIL rne_odd got %h want 3f800002", result);
    end
    ack();
    send(1'b0, 8'd127, 25'h0800000, 1'b1, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (result !== 32'h3F800000) begin
      errors++; $display("FAIL rne_even got %h want 3f800000", result);
    end
    ack();
  endtask

  task automatic test_round_carry();
    int cyc;
    send(1'b0, 8'd127, 25'h0FFFFFF, 1'b1, 1'b1, 1'b0);
    wait_valid(cyc);
    checks++;
    if (result !== 32'h40000000) begin
      errors++; $display("FAIL rcarry_result got %h want 40000000", result);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rcarry_ovf got %b want 0", overflow);
    end
    ack();
    send(1'b0, 8'd254, 25'h1000000, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (result !== 32'h7F800000) begin
      errors++; $display("FAIL ovf_result got %h want 7f800000", result);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    ack();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_underflow();
    int cyc;
    send(1'b0, 8'd3, 25'h0000100, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL unf_result got %h want 0", result);
    end
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL unf_flag got %b want 1", underflow);
    end
    ack();
    send(1'b1, 8'd0, 25'h0, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL zero_latency got %0d want 2", cyc);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL zero_result got %h want 0", result);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL zero_unf got %b want 0", underflow);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int cyc;
    send(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 1'b0);
    wait_valid(cyc);
    sumMantissa = 25'h0800000;
    inValid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({outValid, inReady} !== 2'b10) begin
        errors++;
        $display("FAIL hold_hs got v=%b r=%b want v=1 r=0",
                 outValid, inReady);
      end
      checks++;
      if (result !== 32'h40000000) begin
        errors++; $display("FAIL hold_result got %h want 40000000", result);
      end
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    inValid  = 1'b0;
    checks++;
    if ({outValid, inReady} !== 2'b01) begin
      errors++;
      $display("FAIL same_edge got v=%b r=%b want v=0 r=1",
               outValid, inReady);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    send(1'b0, 8'd130, 25'h0000001, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({outValid, inReady} !== 2'b01) begin
      errors++;
      $display("FAIL abort_hs got v=%b r=%b want v=0 r=1",
               outValid, inReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 3) begin
      errors++; $display("FAIL abort_latency got %0d want 3", cyc);
    end
    checks++;
    if (result !== 32'h3F800002) begin
      errors++; $display("FAIL abort_result got %h want 3f800002", result);
    end
    ack();
  endtask

  initial begin
    rst_n       = 1'b0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    sign        = 1'b0;
    exponentIn  = '0;
    sumMantissa = '0;
    guardBit    = 1'b0;
    roundBit    = 1'b0;
    stickyBit   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_normalised();
    test_cancellation();
    test_rne();
    test_round_carry();
    test_underflow();
    test_backpressure();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
